// File: rtl/renkon_pkg.sv
// renkon_pkg: shared renkon constants and the net loader state type
package renkon_pkg;
  localparam int DWIDTH = 16;
  localparam int RENKON_CORE = 4;
  localparam int RENKON_CORELOG = 2;
  localparam int RENKON_NETSIZE = 11;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_FIN} loader_state_t;
endpackage

// File: rtl/renkon_net_loader_if.sv
// renkon_net_loader_if: control, weight stream and net-memory write port of the loader
interface renkon_net_loader_if #(
  parameter int DWIDTH = renkon_pkg::DWIDTH,
  parameter int CORELOG = renkon_pkg::RENKON_CORELOG,
  parameter int NETSIZE = renkon_pkg::RENKON_NETSIZE
);
  logic start;
  logic [CORELOG:0] core_num;
  logic [NETSIZE:0] words;
  logic [NETSIZE-1:0] net_offset;
  logic s_valid;
  logic [DWIDTH-1:0] s_data;
  logic s_ready;
  logic [CORELOG-1:0] net_sel;
  logic net_we;
  logic [NETSIZE-1:0] net_addr;
  logic [DWIDTH-1:0] net_wdata;
  logic busy;
  logic done;
  modport master (
    input start, core_num, words, net_offset, s_valid, s_data,
    output s_ready, net_sel, net_we, net_addr, net_wdata, busy, done
  );
  modport slave (
    output start, core_num, words, net_offset, s_valid, s_data,
    input s_ready, net_sel, net_we, net_addr, net_wdata, busy, done
  );
endinterface

// File: rtl/renkon_loader_addrgen.sv
// renkon_loader_addrgen: core/word counters, last-word flag and wrapping address adder
module renkon_loader_addrgen #(
  parameter int CORELOG = renkon_pkg::RENKON_CORELOG,
  parameter int NETSIZE = renkon_pkg::RENKON_NETSIZE
) (
  input  logic clk,
  input  logic xrst,
  input  logic clr,
  input  logic inc,
  input  logic [CORELOG:0] core_num,
  input  logic [NETSIZE:0] words,
  input  logic [NETSIZE-1:0] offset,
  output logic [CORELOG-1:0] core_cnt,
  output logic [NETSIZE-1:0] addr,
  output logic last
);
  logic [NETSIZE-1:0] word_cnt;
  logic word_last;
  assign word_last = {1'b0, word_cnt} == words - 1'b1;
  assign last = word_last && ({1'b0, core_cnt} == core_num - 1'b1);
  assign addr = offset + word_cnt;
  always_ff @(posedge clk or posedge xrst)
    if (xrst) begin
      word_cnt <= '0;
      core_cnt <= '0;
    end else if (clr) begin
      word_cnt <= '0;
      core_cnt <= '0;
    end else if (inc) begin
      word_cnt <= word_last ? '0 : word_cnt + 1'b1;
      core_cnt <= word_last ? core_cnt + 1'b1 : core_cnt;
    end
endmodule

// File: rtl/renkon_net_loader.sv
// renkon_net_loader: streams signed weights core-major into the renkon net memories
// Optional RENKON_LOADER_CHKSUM_EN adds a 32-bit sign-extended sum of accepted words.
module renkon_net_loader #(
  parameter int DWIDTH = renkon_pkg::DWIDTH,
  parameter int CORE = renkon_pkg::RENKON_CORE,
  parameter int CORELOG = renkon_pkg::RENKON_CORELOG,
  parameter int NETSIZE = renkon_pkg::RENKON_NETSIZE
) (
  input logic clk,
  input logic xrst,
  renkon_net_loader_if.master bus
`ifdef RENKON_LOADER_CHKSUM_EN
  ,
  output logic [31:0] chksum
`endif
);
  import renkon_pkg::*;
  loader_state_t state, state_n;
  logic [CORELOG:0] cfg_core;
  logic [NETSIZE:0] cfg_words;
  logic [NETSIZE-1:0] cfg_offset;
  logic [CORELOG-1:0] core_cnt;
  logic [NETSIZE-1:0] addr;
  logic last, hs, launch, noop;
  assign launch = state == L_IDLE && bus.start;
  assign noop = bus.core_num == '0 || bus.words == '0 || bus.core_num > (CORELOG+1)'(CORE);
  assign hs = state == L_LOAD && bus.s_valid;
  assign bus.s_ready = state == L_LOAD;
  assign bus.busy = state != L_IDLE;
  assign bus.done = state == L_FIN;
  always_comb begin
    state_n = state;
    state_n = state == L_IDLE ? (bus.start ? (noop ? L_FIN : L_LOAD) : L_IDLE)
            : state == L_LOAD ? (hs && last ? L_FIN : L_LOAD)
            : L_IDLE;
  end
  always_ff @(posedge clk or posedge xrst)
    if (xrst) state <= L_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge xrst)
    if (xrst) begin
      cfg_core <= '0;
      cfg_words <= '0;
      cfg_offset <= '0;
    end else if (launch) begin
      cfg_core <= bus.core_num;
      cfg_words <= bus.words;
      cfg_offset <= bus.net_offset;
    end
  renkon_loader_addrgen #(.CORELOG(CORELOG), .NETSIZE(NETSIZE)) u_addrgen (
    .clk(clk),
    .xrst(xrst),
    .clr(launch),
    .inc(hs),
    .core_num(cfg_core),
    .words(cfg_words),
    .offset(cfg_offset),
    .core_cnt(core_cnt),
    .addr(addr),
    .last(last)
  );
  // Write port is registered one cycle behind the handshake; sel/addr/data hold between writes.
  always_ff @(posedge clk or posedge xrst)
    if (xrst) begin
      bus.net_we <= 1'b0;
      bus.net_sel <= '0;
      bus.net_addr <= '0;
      bus.net_wdata <= '0;
    end else begin
      bus.net_we <= hs;
      if (hs) begin
        bus.net_sel <= core_cnt;
        bus.net_addr <= addr;
        bus.net_wdata <= bus.s_data;
      end
    end
`ifdef RENKON_LOADER_CHKSUM_EN
  always_ff @(posedge clk or posedge xrst)
    if (xrst) chksum <= '0;
    else if (launch) chksum <= '0;
    else if (hs) chksum <= chksum + 32'(signed'(bus.s_data));
`endif
endmodule
